// File: rtl/erasable_mem_ctrl.sv
// AGC erasable memory controller: READ/WRITE/INCR/DECR over valid/ready,
// ones' complement read-modify-write against a registered-output memory.
module erasable_mem_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 15,
  parameter int MEM_DEPTH = 2047,
  parameter int ZERO_ADDR = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [1:0]        resp_err,
  output logic              resp_ovf,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_DECR  = 2'b11;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_FIXED = 2'b01;
  localparam logic [1:0] ERR_ZERO  = 2'b10;
  localparam logic [1:0] ERR_RANGE = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    DONE
  } state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [1:0]  cls_err;
  logic        is_wr_op;

  logic [DATA_W-1:0] opnd;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] res;
  logic              ovf;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign mem_we     = (state == WR);

  assign is_wr_op = (req_op != OP_READ);

  // Range check dominates; fixed/zero only matter for ops that write.
  always_comb begin
    cls_err = ERR_OK;
    if (req_addr >= ADDR_W'(MEM_DEPTH))
      cls_err = ERR_RANGE;
    else if (is_wr_op && (req_addr[ADDR_W-1 -: 2] != 2'b00))
      cls_err = ERR_FIXED;
    else if (is_wr_op && (req_addr == ADDR_W'(ZERO_ADDR)))
      cls_err = ERR_ZERO;
  end

  // DECR adds ones' complement -1 (all ones but LSB); end-around carry.
  always_comb begin
    opnd = (op_q == OP_DECR) ? ~DATA_W'(1) : DATA_W'(1);
    sum  = {1'b0, mem_dout} + {1'b0, opnd};
    res  = sum[DATA_W-1:0] + DATA_W'(sum[DATA_W]);
    ovf  = (mem_dout[DATA_W-1] == opnd[DATA_W-1]) &&
           (res[DATA_W-1] != mem_dout[DATA_W-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= OP_READ;
      resp_rdata <= '0;
      resp_err   <= ERR_OK;
      resp_ovf   <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            op_q       <= req_op;
            resp_rdata <= '0;
            resp_err   <= cls_err;
            resp_ovf   <= 1'b0;
            if (cls_err != ERR_OK) begin
              state <= DONE;
            end else begin
              mem_addr <= req_addr;
              if (req_op == OP_WRITE) begin
                mem_din <= req_wdata;
                state   <= WR;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: state <= CAP;
        CAP: begin
          if (op_q == OP_READ) begin
            resp_rdata <= mem_dout;
            state      <= DONE;
          end else begin
            mem_din    <= res;
            resp_rdata <= res;
            resp_ovf   <= ovf;
            state      <= WR;
          end
        end
        WR: state <= DONE;
        DONE: begin
          if (resp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/erasable_mem_ctrl.md
Name: erasable_mem_ctrl

Overview:
- Initiator-side controller that drives the 15-bit AGC data memory. Handles its Addr/DataIn/regWE inputs and consumes its registered DataOut.
- Accepts single-word requests from the CPU sequencer over a valid/ready handshake. Supported ops: READ, WRITE, and in-place INCR/DECR (read-modify-write in ones' complement).
- Rejects writes to fixed memory, to the zero register and to out-of-range addresses before touching memory. Returns data, error code and overflow flag on a held response channel.

Parameters:
- ADDR_W, 12, address width.
- DATA_W, 15, word width (ones' complement, bit 14 = sign).
- MEM_DEPTH, 2047, number of implemented words (valid addresses 0..MEM_DEPTH-1).
- ZERO_ADDR, 7, write-protected zero register address.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle, request accepted on valid&ready edge.
- req_op  in  2  00 READ, 01 WRITE, 10 INCR, 11 DECR.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data (WRITE only).
- resp_valid  out  1  response held until accepted.
- resp_ready  in  1  response consumed on valid&ready edge.
- resp_rdata  out  DATA_W  READ: word read; INCR/DECR: new value written; WRITE/error: 0.
- resp_err  out  2  00 ok, 01 write to fixed, 10 write to zero reg, 11 address out of range.
- resp_ovf  out  1  INCR/DECR sign overflow.
- mem_addr  out  ADDR_W  to memory Addr.
- mem_din  out  DATA_W  to memory DataIn.
- mem_we  out  1  to memory regWE.
- mem_dout  in  DATA_W  from memory DataOut (registered: reflects mem_addr sampled at previous edge).

Behaviour:
- Reset (rst_n low at edge): state IDLE; resp_valid=0, resp_rdata=0, resp_err=0, resp_ovf=0, mem_addr=0, mem_din=0. mem_we is decoded from state==WR, so it is 0 from the first post-reset cycle.
- A WR cycle in flight when reset is sampled completes its memory write at that edge. No further write follows.

States and transitions:
- IDLE: req_ready=1. On accept, latch op, addr and wdata into registers, then classify:
  - addr >= MEM_DEPTH gives err 11.
  - Otherwise, for op != READ: addr[11:10] != 00 gives err 01, and addr == ZERO_ADDR gives err 10.
  - On any error, go to DONE with no memory access.
  - Otherwise READ/INCR/DECR go to RD, and WRITE goes to WR with mem_din=wdata.
- RD: mem_addr=latched addr, mem_we=0. Go to CAP.
- CAP: capture mem_dout.
  - READ: resp_rdata=mem_dout, go to DONE.
  - INCR/DECR: compute result, set mem_din=result, go to WR.
- WR: mem_we=1 for exactly this one cycle; mem_addr and mem_din are stable. Go to DONE.
- DONE: resp_valid=1; all resp_* fields stable. When resp_ready=1, go to IDLE (resp_valid drops next cycle). req_ready stays 0 until back in IDLE; there is no same-cycle turnaround.

Latency from accept edge to first resp_valid cycle:
- error: 1
- WRITE: 2
- READ: 3
- INCR/DECR: 4

Other rules:
- mem_addr holds its last value in IDLE/DONE. mem_we is never 1 outside WR.

Arithmetic (15-bit ones' complement, end-around carry):
- INCR adds 0x0001; DECR adds 0x7FFE.
- End-around carry: sum = a + b (16-bit); result = sum[14:0] + sum[15].
- resp_ovf=1 when both operands have the same sign bit and the result sign differs; otherwise 0. resp_ovf is 0 for READ, WRITE and errors.
- Boundary values:
  - INCR 0x3FFF gives 0x4000, ovf=1.
  - INCR 0x7FFF (-0) gives 0x0001.
  - DECR 0x0001 gives 0x7FFF (-0).
  - DECR 0x4000 gives 0x3FFF, ovf=1.
- The result is written back even when ovf=1.
- Reads of fixed memory (addr[11:10] != 00, below MEM_DEPTH) and of ZERO_ADDR are legal.

Test Plan:
- WRITE addr 0x010 data 0x1234: mem_we high exactly 1 cycle with mem_addr=0x010, mem_din=0x1234; resp 2 cycles after accept, err 00. Then READ 0x010: resp_rdata=0x1234 at 3 cycles.
- Preload 0x020=0x3FFF, INCR 0x020: rdata=0x4000, ovf=1, memory holds 0x4000. Preload 0x7FFF, INCR: rdata=0x0001, ovf=0. DECR 0x0001: rdata=0x7FFF.
- WRITE 0x400: err 01, resp after 1 cycle. INCR 0x007: err 10. READ 0x7FF: err 11. In all three, mem_we never asserts.
- READ 0x400 (fixed) and READ 0x007: err 00, data equals preloaded file contents.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid. Response fields stay constant, req_ready stays 0, and a req_valid presented meanwhile is not accepted until after the resp handshake.
- Reset mid-op: INCR in progress, rst_n low during CAP. mem_we never asserts, memory is unchanged, and the next cycle shows IDLE with req_ready=1 and all resp outputs 0.
